// File: rtl/piso_ser.sv
// Parallel-in serial-out shifter: accepts a WIDTH-bit word and emits it one bit per clock.
// Optional even-parity trailer bit enabled by defining PISO_SER_PARITY_EN.
module piso_ser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_done
);

`ifdef PISO_SER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME);
  localparam logic [CW-1:0] PEN_CNT  = CW'(FRAME - 1);
`ifdef PISO_SER_PARITY_EN
  localparam logic [CW-1:0] DATA_CNT = CW'(WIDTH);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    SHIFT = 2'b10
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [CW-1:0]    cnt_r;
`ifdef PISO_SER_PARITY_EN
  logic             parity_r;

  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction
`endif

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return w[WIDTH-1];
    end else begin
      return w[0];
    end
  endfunction

  // shreg_r always holds the bits still to be sent, next one at the head position
  function automatic logic [WIDTH-1:0] tail_bits(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return {w[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, w[WIDTH-1:1]};
    end
  endfunction

  // Frame FSM; all outputs are registered and cnt_r counts bits already on dout
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      shreg_r    <= '0;
      cnt_r      <= '0;
      din_ready  <= 1'b1;
      dout       <= IDLE_BIT;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
`ifdef PISO_SER_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE, SHIFT: begin
          if (din_valid && din_ready) begin
            state_r    <= SHIFT;
            dout       <= head_bit(din);
            shreg_r    <= tail_bits(din);
            cnt_r      <= CW'(1);
            dout_valid <= 1'b1;
            frame_done <= 1'b0;
            din_ready  <= 1'b0;
`ifdef PISO_SER_PARITY_EN
            parity_r   <= even_parity(din);
`endif
          end else if ((state_r == SHIFT) && (cnt_r < LAST_CNT)) begin
            state_r    <= SHIFT;
`ifdef PISO_SER_PARITY_EN
            dout       <= (cnt_r == DATA_CNT) ? parity_r : head_bit(shreg_r);
`else
            dout       <= head_bit(shreg_r);
`endif
            shreg_r    <= tail_bits(shreg_r);
            cnt_r      <= cnt_r + CW'(1);
            dout_valid <= 1'b1;
            frame_done <= (cnt_r == PEN_CNT);
            din_ready  <= (cnt_r == PEN_CNT);
          end else begin
            state_r    <= IDLE;
            shreg_r    <= '0;
            cnt_r      <= '0;
            din_ready  <= 1'b1;
            dout       <= IDLE_BIT;
            dout_valid <= 1'b0;
            frame_done <= 1'b0;
          end
        end
        default: begin
          state_r    <= IDLE;
          shreg_r    <= '0;
          cnt_r      <= '0;
          din_ready  <= 1'b1;
          dout       <= IDLE_BIT;
          dout_valid <= 1'b0;
          frame_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_ser.sv
// Directed bench for piso_ser: table of single frames plus hand-written multi-cycle sequences.
module tb_piso_ser;

`ifdef PISO_SER_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       sel = 1'b0;

  logic rdy_m, dout_m, dv_m, fd_m;
  logic rdy_l, dout_l, dv_l, fd_l;
  logic c_rdy, c_dout, c_dv, c_fd;

  int n_checks = 0;
  int n_fail   = 0;

  piso_ser #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy_m), .dout(dout_m), .dout_valid(dv_m), .frame_done(fd_m)
  );

  piso_ser #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy_l), .dout(dout_l), .dout_valid(dv_l), .frame_done(fd_l)
  );

  assign c_rdy  = sel ? rdy_l  : rdy_m;
  assign c_dout = sel ? dout_l : dout_m;
  assign c_dv   = sel ? dv_l   : dv_m;
  assign c_fd   = sel ? fd_l   : fd_m;

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] word;
    logic [7:0] exp;   // bits in transmission order, exp[7] first
    logic       par;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " idle ready"}, c_rdy, 1'b1);
    chk({tag, " idle dout"},  c_dout, 1'b1);
    chk({tag, " idle valid"}, c_dv, 1'b0);
    chk({tag, " idle done"},  c_fd, 1'b0);
  endtask

  task automatic start(input logic [7:0] word);
    din = word;
    din_valid = 1'b1;
    tick();
  endtask

  // Checks one whole frame; from bit index hold_from onward, hold_word is offered
  task automatic check_frame(input string tag, input logic [7:0] exp, input logic par,
                             input logic [7:0] hold_word, input int hold_from);
    logic eb;
    for (int i = 0; i < FRAME; i++) begin
      eb = (i < 8) ? exp[7 - i] : par;
      chk($sformatf("%s bit%0d dout", tag, i), c_dout, eb);
      chk($sformatf("%s bit%0d valid", tag, i), c_dv, 1'b1);
      chk($sformatf("%s bit%0d done", tag, i), c_fd, (i == FRAME - 1));
      chk($sformatf("%s bit%0d ready", tag, i), c_rdy, (i == FRAME - 1));
      if (i >= hold_from) begin
        din = hold_word;
        din_valid = 1'b1;
      end else begin
        din = 8'h00;
        din_valid = 1'b0;
      end
      tick();
    end
    din_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{word: 8'h55, exp: 8'b0101_0101, par: 1'b0};
    vecs[1] = '{word: 8'h00, exp: 8'b0000_0000, par: 1'b0};
    vecs[2] = '{word: 8'hFF, exp: 8'b1111_1111, par: 1'b0};
    vecs[3] = '{word: 8'h80, exp: 8'b1000_0000, par: 1'b1};
    vecs[4] = '{word: 8'h07, exp: 8'b0000_0111, par: 1'b1};

    rst = 1'b0;
    @(negedge clk);
    tick();
    check_idle("reset");
    rst = 1'b1;
    tick();
    check_idle("post-reset");

    for (int v = 0; v < 5; v++) begin
      start(vecs[v].word);
      check_frame($sformatf("vec%0d", v), vecs[v].exp, vecs[v].par, 8'h00, 99);
      check_idle($sformatf("vec%0d", v));
    end

    // back-to-back with din_valid held high; din changes right after capture
    start(8'hA5);
    check_frame("b2b_a5", 8'b1010_0101, 1'b0, 8'h3C, 0);
    check_frame("b2b_3c", 8'b0011_1100, 1'b0, 8'h00, 99);
    check_idle("b2b");

    // word offered from bit 3 is refused until the last bit
    start(8'h96);
    check_frame("busy_96", 8'b1001_0110, 1'b0, 8'hFF, 2);
    check_frame("busy_ff", 8'b1111_1111, 1'b0, 8'h00, 99);
    check_idle("busy");

    // reset after three bits, with a simultaneous offered word
    start(8'hC3);
    din_valid = 1'b0;
    chk("rstmid bit0", c_dout, 1'b1);
    tick();
    chk("rstmid bit1", c_dout, 1'b1);
    tick();
    chk("rstmid bit2", c_dout, 1'b0);
    chk("rstmid bit2 valid", c_dv, 1'b1);
    rst = 1'b0;
    din = 8'h0F;
    din_valid = 1'b1;
    tick();
    check_idle("rstmid");
    rst = 1'b1;
    din_valid = 1'b0;
    tick();
    check_idle("rstmid2");
    start(8'h0F);
    check_frame("after_rst_0f", 8'b0000_1111, 1'b0, 8'h00, 99);
    check_idle("after_rst");

    // LSB-first instance
    rst = 1'b0;
    tick();
    rst = 1'b1;
    sel = 1'b1;
    tick();
    check_idle("lsb");
    start(8'h01);
    check_frame("lsb_01", 8'b1000_0000, 1'b1, 8'h00, 99);
    check_idle("lsb_end");
    start(8'hC5);
    check_frame("lsb_c5", 8'b1010_0011, 1'b0, 8'h00, 99);
    check_idle("lsb_end2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_ser.md
PISO_SER -- requirements
Module: piso_ser

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 means bit WIDTH-1 is serialized first, 0 means bit 0 is serialized first.
REQ-003 The block SHALL have parameter IDLE_BIT, default 1, giving the level driven on dout when no frame is active.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-006 din  input  WIDTH  parallel word to serialize.
REQ-007 din_valid  input  1  din holds a word offered for transfer.
REQ-008 din_ready  output  1  block accepts a word this cycle.
REQ-009 dout  output  1  serial bit stream, one bit per clock; feeds the downstream pattern detector's serial input.
REQ-010 dout_valid  output  1  dout carries a frame bit this cycle.
REQ-011 frame_done  output  1  single-cycle pulse coincident with the last bit of a frame.

Function
REQ-012 The block SHALL be a two-state FSM: IDLE and SHIFT.
REQ-013 IDLE: din_ready=1, dout=IDLE_BIT, dout_valid=0, frame_done=0.
REQ-014 Transfer SHALL occur on a rising edge where din_valid=1 and din_ready=1; din SHALL be captured into a WIDTH-bit shift register and the FSM SHALL enter SHIFT.
REQ-015 Latency: the first frame bit SHALL appear on dout with dout_valid=1 in the cycle immediately after the transfer edge.
REQ-016 SHIFT: each cycle drives the next bit in the MSB_FIRST order on dout with dout_valid=1; a bit counter of width clog2(WIDTH+1) SHALL track bits sent.
REQ-017 In SHIFT, din_ready SHALL be 1 only during the last frame bit; otherwise 0, and din/din_valid SHALL be ignored.
REQ-018 On the last bit, frame_done=1; if din_valid=1 that cycle, the new word SHALL be captured and its first bit SHALL follow with no gap (FSM stays in SHIFT, counter restarts).
REQ-019 On the last bit with din_valid=0, the FSM SHALL return to IDLE on the next edge.
REQ-020 Changes to din after capture SHALL NOT affect the frame in progress.
REQ-021 The counter SHALL NOT wrap or exceed the frame length; any illegal FSM encoding SHALL recover to IDLE on the next edge.

Reset
REQ-022 While rst=0 at a rising edge, the block SHALL enter IDLE, clear the counter and shift register, and next cycle present din_ready=1, dout=IDLE_BIT, dout_valid=0, frame_done=0.
REQ-023 Reset mid-frame SHALL abandon the frame with no frame_done pulse; reset has priority over a simultaneous transfer.

Configuration
REQ-024 Macro PISO_SER_PARITY_EN: when defined, each frame SHALL be WIDTH+1 bits, the data bits followed by one even-parity bit (XOR of the captured word); frame_done and din_ready SHALL move to the parity-bit cycle.
REQ-025 Without PISO_SER_PARITY_EN, frames SHALL be exactly WIDTH bits and no parity logic SHALL be present.

Verification
REQ-026 WIDTH=8, MSB_FIRST=1: transfer 8'h55 -> dout=0,1,0,1,0,1,0,1 on the 8 following cycles, dout_valid=1 throughout, frame_done on the 8th; downstream detector asserts its flag.
REQ-027 Back-to-back: 8'hA5 then 8'h3C, din_valid held high -> 16 consecutive valid bits 1010_0101_0011_1100, no idle cycle, frame_done at bits 8 and 16.
REQ-028 Offer 8'hFF during bit 3 of a frame -> din_ready=0, word not taken, current frame bits unchanged; accepted at bit 8.
REQ-029 rst=0 after 3 bits of 8'hC3 -> next cycle dout=1, dout_valid=0, din_ready=1, no frame_done; a following 8'h0F serializes correctly.
REQ-030 MSB_FIRST=0, 8'h01 -> dout=1,0,0,0,0,0,0,0; with PISO_SER_PARITY_EN, 8'h07 -> 9 bits, 9th = 1, frame_done on the 9th.
